// File: rtl/rr_grant_arbiter4.sv
// Four-way round-robin arbiter with one-cycle req-to-grant latency and registered outputs.
// No backpressure: an owner keeps the grant until done, request drop, or hold-limit expiry.
module rr_grant_arbiter4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [1:0]       r_last;
   logic [3:0]       r_grant;
   logic [1:0]       r_idx;
   logic             r_valid;
   logic             r_timeout;

   logic             w_rel_done;
   logic             w_rel_drop;
   logic             w_rel_to;
   logic             w_rel;
   logic [3:0]       w_cand;
   logic [2:0]       w_pick;

   // Returns {found, index}; scans last+1 .. last+4 so the nearest candidate after last wins.
   function automatic logic [2:0] f_pick(input logic [3:0] cand, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] k;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         k = last + 2'(i);
         if (cand[k]) res = {1'b1, k};
      end
      return res;
   endfunction

   always_comb begin
      w_rel_done = done;
      w_rel_drop = ~req[r_idx];
      w_rel_to   = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
      w_rel      = w_rel_done | w_rel_drop | w_rel_to;
      w_cand     = (r_state == ST_BUSY) ? (req & ~r_grant) : req;
      w_pick     = f_pick(w_cand, r_last);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
         r_last     <= 2'd3;
         r_grant    <= 4'b0000;
         r_idx      <= 2'd0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick[2]) begin
                  r_state    <= ST_BUSY;
                  r_idx      <= w_pick[1:0];
                  r_grant    <= 4'b0001 << w_pick[1:0];
                  r_valid    <= 1'b1;
                  r_hold_cnt <= '0;
                  r_last     <= w_pick[1:0];
               end
            end
            default: begin
               if (!w_rel) begin
                  r_hold_cnt <= r_hold_cnt + CNT_W'(1);
               end else begin
                  // A done or drop in the same cycle suppresses the forced-release flag.
                  r_timeout <= w_rel_to & ~w_rel_done & ~w_rel_drop;
                  if (w_pick[2]) begin
                     r_idx      <= w_pick[1:0];
                     r_grant    <= 4'b0001 << w_pick[1:0];
                     r_hold_cnt <= '0;
                     r_last     <= w_pick[1:0];
                  end else begin
                     r_state <= ST_IDLE;
                     r_grant <= 4'b0000;
                     r_valid <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = r_valid;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Bench for rr_grant_arbiter4: directed scenarios then random traffic, scored against a queue-fed model.
module tb_rr_grant_arbiter4;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] idx;
      logic       v;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant0, grant1;
   logic [1:0] idx0, idx1;
   logic       vld0, vld1, to0, to1;

   int checks = 0;
   int errors = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Model state per instance: current owner (-1 = none), cycles held so far, last winner.
   int         m_owner[2];
   int         m_held[2];
   int         m_last[2];
   logic [1:0] m_idx[2];
   int         maxh[2] = '{8, 1};

   always #5 clk = ~clk;

   rr_grant_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .grant(grant0), .grant_idx(idx0), .grant_valid(vld0), .timeout(to0)
   );

   rr_grant_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .grant(grant1), .grant_idx(idx1), .grant_valid(vld1), .timeout(to1)
   );

   function automatic int search(input logic [3:0] cand, input int last);
      for (int off = 1; off <= 4; off++) begin
         if (cand[(last + off) % 4]) return (last + off) % 4;
      end
      return -1;
   endfunction

   task automatic model_step(input int k, input logic rs, input logic [3:0] rq, input logic dn,
                             output exp_t e);
      int         w;
      logic       to;
      logic [3:0] cand;
      to = 1'b0;
      if (rs) begin
         m_owner[k] = -1;
         m_held[k]  = 0;
         m_last[k]  = 3;
         m_idx[k]   = 2'd0;
      end else if (m_owner[k] < 0) begin
         w = search(rq, m_last[k]);
         if (w >= 0) begin
            m_owner[k] = w;
            m_held[k]  = 1;
            m_last[k]  = w;
         end
      end else if (dn || !rq[m_owner[k]] || m_held[k] == maxh[k]) begin
         to   = (m_held[k] == maxh[k]) && !dn && rq[m_owner[k]];
         cand = rq;
         cand[m_owner[k]] = 1'b0;
         w = search(cand, m_last[k]);
         if (w >= 0) begin
            m_owner[k] = w;
            m_held[k]  = 1;
            m_last[k]  = w;
         end else begin
            m_owner[k] = -1;
         end
      end else begin
         m_held[k] = m_held[k] + 1;
      end
      if (m_owner[k] >= 0) m_idx[k] = 2'(m_owner[k]);
      e.g   = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
      e.idx = m_idx[k];
      e.v   = (m_owner[k] >= 0);
      e.to  = to;
   endtask

   task automatic drive(input logic rs, input logic [3:0] rq, input logic dn);
      exp_t e;
      reset = rs;
      req   = rq;
      done  = dn;
      model_step(0, rs, rq, dn, e);
      q0.push_back(e);
      model_step(1, rs, rq, dn, e);
      q1.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: outputs are registered, so each sampled edge answers the oldest pending stimulus.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {grant0, idx0, vld0, to0};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL out_hold8 t=%0t got g=%b idx=%0d v=%b to=%b want g=%b idx=%0d v=%b to=%b",
                        $time, a.g, a.idx, a.v, a.to, e.g, e.idx, e.v, e.to);
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {grant1, idx1, vld1, to1};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL out_hold1 t=%0t got g=%b idx=%0d v=%b to=%b want g=%b idx=%0d v=%b to=%b",
                        $time, a.g, a.idx, a.v, a.to, e.g, e.idx, e.v, e.to);
            end
         end
      end
   end

   initial begin
      logic [3:0] rq;
      logic       dn;
      logic       rs;
      reset = 1'b1;
      req   = 4'b0000;
      done  = 1'b0;
      // Reset, single requester grant, done release and re-grant.
      drive(1'b1, 4'b0000, 1'b0);
      drive(1'b1, 4'b0000, 1'b0);
      drive(1'b0, 4'b0001, 1'b0);
      drive(1'b0, 4'b0001, 1'b0);
      drive(1'b0, 4'b0001, 1'b1);
      repeat (3) drive(1'b0, 4'b0001, 1'b0);
      // All requesting, done every second cycle: rotation without bubbles.
      drive(1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b0, 4'b1111, 1'(i % 2));
      // Single requester with no done: hold-limit expiry and timeout pulse.
      drive(1'b1, 4'b0000, 1'b0);
      repeat (12) drive(1'b0, 4'b0010, 1'b0);
      // Owner 2 drops while 3 and 0 request: 3 wins.
      drive(1'b1, 4'b0000, 1'b0);
      drive(1'b0, 4'b0100, 1'b0);
      drive(1'b0, 4'b0100, 1'b0);
      repeat (2) drive(1'b0, 4'b1001, 1'b0);
      // done coincides with hold expiry: handoff to 2, no timeout.
      drive(1'b1, 4'b0000, 1'b0);
      repeat (8) drive(1'b0, 4'b0101, 1'b0);
      drive(1'b0, 4'b0101, 1'b1);
      repeat (2) drive(1'b0, 4'b0101, 1'b0);
      // Reset mid-grant, then last restarts at 3 so 2 wins over 3.
      drive(1'b0, 4'b0100, 1'b0);
      drive(1'b1, 4'b0100, 1'b0);
      repeat (3) drive(1'b0, 4'b1100, 1'b0);
      // Random traffic: requests change occasionally so hold limits are reached.
      rq = 4'b0000;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) rq = 4'($urandom);
         dn = ($urandom_range(0, 4) == 0);
         rs = ($urandom_range(0, 80) == 0);
         drive(rs, rq, dn);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain got pending=%0d/%0d want 0/0", q0.size(), q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
